// File: rtl/turret_sequencer_if.sv
// Turret sequencer bus: operator/tracker inputs and servo command outputs.
// The master side drives switches, fire trigger and targets; the slave side
// is the sequencer itself.
interface turret_sequencer_if #(
  parameter int unsigned POS_W = 25
);
  logic             i_Manual;
  logic             i_Switch_1;
  logic             i_Switch_2;
  logic             i_Switch_3;
  logic             i_Switch_4;
  logic             i_Fire_Req;
  logic             i_Target_Valid;
  logic [POS_W-1:0] i_X_Target;
  logic [POS_W-1:0] i_Y_Target;

  logic [3:0]       o_Pan_Cmd;
  logic [3:0]       o_Tilt_Cmd;
  logic [3:0]       o_Fire_Cmd;
  logic [POS_W-1:0] o_X_Pos;
  logic [POS_W-1:0] o_Y_Pos;
  logic             o_On_Target;
  logic             o_Busy;
  logic             o_LED_1;
  logic             o_LED_2;
  logic             o_LED_3;
  logic             o_LED_4;

  modport master (
    output i_Manual, i_Switch_1, i_Switch_2, i_Switch_3, i_Switch_4,
           i_Fire_Req, i_Target_Valid, i_X_Target, i_Y_Target,
    input  o_Pan_Cmd, o_Tilt_Cmd, o_Fire_Cmd, o_X_Pos, o_Y_Pos,
           o_On_Target, o_Busy, o_LED_1, o_LED_2, o_LED_3, o_LED_4
  );

  modport slave (
    input  i_Manual, i_Switch_1, i_Switch_2, i_Switch_3, i_Switch_4,
           i_Fire_Req, i_Target_Valid, i_X_Target, i_Y_Target,
    output o_Pan_Cmd, o_Tilt_Cmd, o_Fire_Cmd, o_X_Pos, o_Y_Pos,
           o_On_Target, o_Busy, o_LED_1, o_LED_2, o_LED_3, o_LED_4
  );
endinterface

// File: rtl/turret_sequencer.sv
// Turret sequencer: arbitrates pan/tilt motion between manual switches and
// automatic tracking, keeps saturating axis positions, and runs the timed
// fire/recoil cycle with a motion interlock while firing.
module turret_sequencer #(
  parameter int unsigned POS_W        = 25,
  parameter int unsigned POS_MAX      = 22727272,
  parameter int unsigned FIRE_TICKS   = 22727272,
  parameter int unsigned RECOIL_TICKS = 22727272,
  parameter int unsigned TICK_W       = 31
) (
  input  logic i_Clk,
  input  logic i_Rst,
  turret_sequencer_if.slave bus
);

  typedef enum logic [1:0] {READY, FIRE, RECOIL} state_t;
  typedef enum logic [1:0] {MV_NONE, MV_DEC, MV_INC} move_t;

  localparam logic [POS_W-1:0]  POS_LIM     = POS_W'(POS_MAX);
  localparam logic [TICK_W-1:0] FIRE_LAST   = TICK_W'(FIRE_TICKS - 1);
  localparam logic [TICK_W-1:0] RECOIL_LAST = TICK_W'(RECOIL_TICKS - 1);

  localparam logic [3:0] CMD_STOP    = 4'd0;
  localparam logic [3:0] CMD_DEC     = 4'd1;
  localparam logic [3:0] CMD_INC     = 4'd2;
  localparam logic [3:0] CMD_RELEASE = 4'd5;

  state_t            state;
  logic [TICK_W-1:0] tick_cnt;
  logic              fire_prev;
  logic [POS_W-1:0]  x_pos, y_pos;
  logic [3:0]        pan_cmd, tilt_cmd, fire_cmd;
  logic              busy;
  logic              led_1, led_2, led_3, led_4;

  logic [POS_W-1:0]  x_tgt, y_tgt;
  logic              on_target;
  logic              accept;
  logic              decide;
  move_t             pan_mv, tilt_mv;

  // One axis decision: dec = left/up, inc = right/down.
  function automatic move_t axis_move(input logic manual, input logic dec_sw,
                                      input logic inc_sw, input logic valid,
                                      input logic [POS_W-1:0] pos,
                                      input logic [POS_W-1:0] tgt);
    move_t m;
    m = MV_NONE;
    if (manual) begin
      if (dec_sw && !inc_sw && (pos != '0))
        m = MV_DEC;
      else if (!dec_sw && inc_sw && (pos < POS_LIM))
        m = MV_INC;
    end else if (valid) begin
      if (pos > tgt)
        m = MV_DEC;
      else if (pos < tgt)
        m = MV_INC;
    end
    return m;
  endfunction

  // Command code for an axis; a stopping axis emits one release code.
  function automatic logic [3:0] next_cmd(input move_t m, input logic [3:0] prev);
    logic [3:0] c;
    case (m)
      MV_DEC:  c = CMD_DEC;
      MV_INC:  c = CMD_INC;
      default: c = ((prev == CMD_DEC) || (prev == CMD_INC)) ? CMD_RELEASE : CMD_STOP;
    endcase
    return c;
  endfunction

  assign x_tgt     = (bus.i_X_Target > POS_LIM) ? POS_LIM : bus.i_X_Target;
  assign y_tgt     = (bus.i_Y_Target > POS_LIM) ? POS_LIM : bus.i_Y_Target;
  assign on_target = bus.i_Target_Valid && (x_pos == x_tgt) && (y_pos == y_tgt);

  // Fire acceptance and motion decision; motion is interlocked from the
  // accepting edge and resumes on the edge that returns to READY.
  always_comb begin
    accept  = (state == READY) && bus.i_Fire_Req && !fire_prev &&
              (bus.i_Manual || on_target);
    decide  = ((state == READY) && !accept) ||
              ((state == RECOIL) && (tick_cnt == RECOIL_LAST));
    pan_mv  = MV_NONE;
    tilt_mv = MV_NONE;
    if (decide) begin
      pan_mv  = axis_move(bus.i_Manual, bus.i_Switch_1, bus.i_Switch_2,
                          bus.i_Target_Valid, x_pos, x_tgt);
      tilt_mv = axis_move(bus.i_Manual, bus.i_Switch_3, bus.i_Switch_4,
                          bus.i_Target_Valid, y_pos, y_tgt);
    end
  end

  // Sequencer state, tick counter, axis positions and all registered outputs.
  always_ff @(posedge i_Clk or posedge i_Rst) begin
    if (i_Rst) begin
      state     <= READY;
      tick_cnt  <= '0;
      fire_prev <= 1'b1;
      x_pos     <= '0;
      y_pos     <= '0;
      pan_cmd   <= CMD_STOP;
      tilt_cmd  <= CMD_STOP;
      fire_cmd  <= CMD_STOP;
      busy      <= 1'b0;
      led_1     <= 1'b0;
      led_2     <= 1'b0;
      led_3     <= 1'b0;
      led_4     <= 1'b0;
    end else begin
      fire_prev <= bus.i_Fire_Req;

      pan_cmd  <= next_cmd(pan_mv, pan_cmd);
      tilt_cmd <= next_cmd(tilt_mv, tilt_cmd);
      led_1    <= (pan_mv == MV_DEC);
      led_2    <= (pan_mv == MV_INC);
      led_3    <= (tilt_mv == MV_DEC);
      led_4    <= (tilt_mv == MV_INC);

      if (pan_mv == MV_DEC)       x_pos <= x_pos - 1'b1;
      else if (pan_mv == MV_INC)  x_pos <= x_pos + 1'b1;
      if (tilt_mv == MV_DEC)      y_pos <= y_pos - 1'b1;
      else if (tilt_mv == MV_INC) y_pos <= y_pos + 1'b1;

      case (state)
        READY: begin
          if (accept) begin
            state    <= FIRE;
            fire_cmd <= CMD_DEC;
            busy     <= 1'b1;
            tick_cnt <= '0;
          end
        end
        FIRE: begin
          if (tick_cnt == FIRE_LAST) begin
            state    <= RECOIL;
            fire_cmd <= CMD_INC;
            tick_cnt <= '0;
          end else begin
            tick_cnt <= tick_cnt + 1'b1;
          end
        end
        RECOIL: begin
          if (tick_cnt == RECOIL_LAST) begin
            state    <= READY;
            fire_cmd <= CMD_STOP;
            busy     <= 1'b0;
            tick_cnt <= '0;
          end else begin
            tick_cnt <= tick_cnt + 1'b1;
          end
        end
        default: begin
          state    <= READY;
          fire_cmd <= CMD_STOP;
          busy     <= 1'b0;
          tick_cnt <= '0;
        end
      endcase
    end
  end

  assign bus.o_Pan_Cmd   = pan_cmd;
  assign bus.o_Tilt_Cmd  = tilt_cmd;
  assign bus.o_Fire_Cmd  = fire_cmd;
  assign bus.o_X_Pos     = x_pos;
  assign bus.o_Y_Pos     = y_pos;
  assign bus.o_On_Target = on_target;
  assign bus.o_Busy      = busy;
  assign bus.o_LED_1     = led_1;
  assign bus.o_LED_2     = led_2;
  assign bus.o_LED_3     = led_3;
  assign bus.o_LED_4     = led_4;

endmodule

// File: tb/tb_turret_sequencer.sv
// Self-checking bench for turret_sequencer: directed scenarios plus a
// randomized run, all checked against a cycle-level behavioural model.
module tb_turret_sequencer;

  localparam int POS_W        = 25;
  localparam int POS_MAX      = 10;
  localparam int FIRE_TICKS   = 4;
  localparam int RECOIL_TICKS = 3;

  logic i_Clk = 1'b0;
  logic i_Rst = 1'b1;

  always #5 i_Clk = ~i_Clk;

  turret_sequencer_if #(.POS_W(POS_W)) bus ();

  turret_sequencer #(
    .POS_W(POS_W), .POS_MAX(POS_MAX), .FIRE_TICKS(FIRE_TICKS),
    .RECOIL_TICKS(RECOIL_TICKS), .TICK_W(31)
  ) dut (
    .i_Clk(i_Clk),
    .i_Rst(i_Rst),
    .bus(bus)
  );

  int checks = 0;
  int errors = 0;

  // Model state: positions, last axis commands, remaining busy cycles,
  // previous trigger sample.
  int m_x, m_y, m_pan, m_tilt, m_busy, m_fprev;

  function automatic int clampt(input logic [POS_W-1:0] t);
    return (t > POS_MAX) ? POS_MAX : int'(t);
  endfunction

  // Position step for one axis: -1 toward 0, +1 toward POS_MAX, 0 hold.
  function automatic int delta(input bit manual, input bit dec, input bit inc,
                               input bit valid, input int pos, input int tgt);
    if (manual) begin
      if (dec && !inc && pos > 0) return -1;
      if (!dec && inc && pos < POS_MAX) return 1;
      return 0;
    end
    if (!valid) return 0;
    if (pos > tgt) return -1;
    if (pos < tgt) return 1;
    return 0;
  endfunction

  function automatic int cmd_of(input int d, input int prev);
    if (d < 0) return 1;
    if (d > 0) return 2;
    return (prev == 1 || prev == 2) ? 5 : 0;
  endfunction

  function automatic bit model_on_target();
    return bus.i_Target_Valid && (m_x == clampt(bus.i_X_Target)) &&
           (m_y == clampt(bus.i_Y_Target));
  endfunction

  function automatic int model_fire();
    if (m_busy == 0) return 0;
    return (m_busy > RECOIL_TICKS) ? 1 : 2;
  endfunction

  task automatic model_reset();
    m_x = 0; m_y = 0; m_pan = 0; m_tilt = 0; m_busy = 0; m_fprev = 1;
  endtask

  task automatic model_step();
    bit was_busy, accept, decide;
    int dx, dy;
    was_busy = (m_busy > 0);
    accept = !was_busy && bus.i_Fire_Req && (m_fprev == 0) &&
             (bus.i_Manual || model_on_target());
    decide = (!was_busy && !accept) || (m_busy == 1);
    dx = 0;
    dy = 0;
    if (decide) begin
      dx = delta(bus.i_Manual, bus.i_Switch_1, bus.i_Switch_2, bus.i_Target_Valid,
                 m_x, clampt(bus.i_X_Target));
      dy = delta(bus.i_Manual, bus.i_Switch_3, bus.i_Switch_4, bus.i_Target_Valid,
                 m_y, clampt(bus.i_Y_Target));
    end
    m_pan  = cmd_of(dx, m_pan);
    m_tilt = cmd_of(dy, m_tilt);
    m_x    = m_x + dx;
    m_y    = m_y + dy;
    m_fprev = bus.i_Fire_Req ? 1 : 0;
    if (accept) m_busy = FIRE_TICKS + RECOIL_TICKS;
    else if (was_busy) m_busy = m_busy - 1;
  endtask

  task automatic step();
    @(posedge i_Clk);
    model_step();
    #1;
  endtask

  task automatic set_idle();
    bus.i_Manual = 1'b0;
    bus.i_Switch_1 = 1'b0; bus.i_Switch_2 = 1'b0;
    bus.i_Switch_3 = 1'b0; bus.i_Switch_4 = 1'b0;
    bus.i_Fire_Req = 1'b0;
    bus.i_Target_Valid = 1'b0;
    bus.i_X_Target = '0; bus.i_Y_Target = '0;
  endtask

  task automatic apply_reset();
    i_Rst = 1'b1;
    #1;
    model_reset();
    @(posedge i_Clk);
    #1;
    i_Rst = 1'b0;
  endtask

  task automatic test_reset();
    set_idle();
    apply_reset();
    checks++; if (bus.o_Pan_Cmd !== 4'd0) begin errors++; $display("FAIL reset_pan: got %0d expected 0", bus.o_Pan_Cmd); end
    checks++; if (bus.o_Tilt_Cmd !== 4'd0) begin errors++; $display("FAIL reset_tilt: got %0d expected 0", bus.o_Tilt_Cmd); end
    checks++; if (bus.o_Fire_Cmd !== 4'd0) begin errors++; $display("FAIL reset_fire: got %0d expected 0", bus.o_Fire_Cmd); end
    checks++; if (bus.o_X_Pos !== 0 || bus.o_Y_Pos !== 0) begin errors++; $display("FAIL reset_pos: got %0d,%0d expected 0,0", bus.o_X_Pos, bus.o_Y_Pos); end
    checks++; if (bus.o_Busy !== 1'b0) begin errors++; $display("FAIL reset_busy: got %0b expected 0", bus.o_Busy); end
    checks++; if ({bus.o_LED_1, bus.o_LED_2, bus.o_LED_3, bus.o_LED_4} !== 4'b0000) begin errors++; $display("FAIL reset_leds: got %b expected 0000", {bus.o_LED_1, bus.o_LED_2, bus.o_LED_3, bus.o_LED_4}); end
    checks++; if (bus.o_On_Target !== 1'b0) begin errors++; $display("FAIL reset_on_target: got %0b expected 0", bus.o_On_Target); end
  endtask

  task automatic test_manual_pan();
    int n2, n5, maxx;
    n2 = 0; n5 = 0; maxx = 0;
    set_idle();
    apply_reset();
    bus.i_Manual = 1'b1;
    bus.i_Switch_2 = 1'b1;
    for (int c = 0; c < 15; c++) begin
      step();
      if (bus.o_Pan_Cmd == 4'd2) n2++;
      if (bus.o_Pan_Cmd == 4'd5) n5++;
      if (int'(bus.o_X_Pos) > maxx) maxx = int'(bus.o_X_Pos);
      checks++; if (bus.o_Pan_Cmd !== 4'(m_pan)) begin errors++; $display("FAIL pan_cmd c%0d: got %0d expected %0d", c, bus.o_Pan_Cmd, m_pan); end
      checks++; if (bus.o_X_Pos !== 25'(m_x)) begin errors++; $display("FAIL pan_x c%0d: got %0d expected %0d", c, bus.o_X_Pos, m_x); end
      checks++; if (bus.o_LED_2 !== (m_pan == 2)) begin errors++; $display("FAIL pan_led2 c%0d: got %0b expected %0b", c, bus.o_LED_2, m_pan == 2); end
    end
    checks++; if (n2 != 10) begin errors++; $display("FAIL pan_right_cycles: got %0d expected 10", n2); end
    checks++; if (n5 != 1) begin errors++; $display("FAIL pan_release_cycles: got %0d expected 1", n5); end
    checks++; if (maxx != 10 || bus.o_X_Pos !== 10) begin errors++; $display("FAIL pan_x_limit: got max %0d final %0d expected 10", maxx, bus.o_X_Pos); end
    checks++; if (bus.o_Pan_Cmd !== 4'd0) begin errors++; $display("FAIL pan_final_cmd: got %0d expected 0", bus.o_Pan_Cmd); end
  endtask

  task automatic test_manual_conflict();
    bus.i_Switch_1 = 1'b1;
    bus.i_Switch_2 = 1'b1;
    for (int c = 0; c < 3; c++) begin
      step();
      checks++; if (bus.o_Pan_Cmd !== 4'd0 || bus.o_X_Pos !== 10) begin errors++; $display("FAIL both_switches c%0d: got cmd %0d x %0d expected cmd 0 x 10", c, bus.o_Pan_Cmd, bus.o_X_Pos); end
    end
    apply_reset();
    bus.i_Switch_2 = 1'b0;
    for (int c = 0; c < 3; c++) begin
      step();
      checks++; if (bus.o_Pan_Cmd !== 4'd0 || bus.o_X_Pos !== 0) begin errors++; $display("FAIL left_at_zero c%0d: got cmd %0d x %0d expected cmd 0 x 0", c, bus.o_Pan_Cmd, bus.o_X_Pos); end
    end
    bus.i_Switch_1 = 1'b0;
    bus.i_Switch_4 = 1'b1;
    for (int c = 0; c < 3; c++) step();
    checks++; if (bus.o_Tilt_Cmd !== 4'd2 || bus.o_Y_Pos !== 3 || bus.o_LED_4 !== 1'b1) begin errors++; $display("FAIL tilt_down: got cmd %0d y %0d led4 %0b expected 2 3 1", bus.o_Tilt_Cmd, bus.o_Y_Pos, bus.o_LED_4); end
    bus.i_Switch_4 = 1'b0;
    bus.i_Switch_3 = 1'b1;
    step();
    checks++; if (bus.o_Tilt_Cmd !== 4'd1 || bus.o_Y_Pos !== 2 || bus.o_LED_3 !== 1'b1 || bus.o_LED_4 !== 1'b0) begin errors++; $display("FAIL tilt_up: got cmd %0d y %0d led3 %0b led4 %0b expected 1 2 1 0", bus.o_Tilt_Cmd, bus.o_Y_Pos, bus.o_LED_3, bus.o_LED_4); end
    bus.i_Switch_3 = 1'b0;
    step();
    checks++; if (bus.o_Tilt_Cmd !== 4'd5 || bus.o_Y_Pos !== 2) begin errors++; $display("FAIL tilt_release: got cmd %0d y %0d expected 5 2", bus.o_Tilt_Cmd, bus.o_Y_Pos); end
  endtask

  task automatic test_auto_track();
    int rises;
    bit prev_on;
    rises = 0; prev_on = 1'b0;
    set_idle();
    apply_reset();
    bus.i_Target_Valid = 1'b1;
    bus.i_X_Target = 25'd3;
    bus.i_Y_Target = 25'd12;
    for (int c = 0; c < 14; c++) begin
      step();
      if (bus.o_On_Target && !prev_on) rises++;
      prev_on = bus.o_On_Target;
      checks++; if (bus.o_X_Pos !== 25'(m_x) || bus.o_Y_Pos !== 25'(m_y)) begin errors++; $display("FAIL track_pos c%0d: got %0d,%0d expected %0d,%0d", c, bus.o_X_Pos, bus.o_Y_Pos, m_x, m_y); end
      checks++; if (bus.o_Pan_Cmd !== 4'(m_pan) || bus.o_Tilt_Cmd !== 4'(m_tilt)) begin errors++; $display("FAIL track_cmd c%0d: got %0d,%0d expected %0d,%0d", c, bus.o_Pan_Cmd, bus.o_Tilt_Cmd, m_pan, m_tilt); end
      checks++; if (bus.o_On_Target !== model_on_target()) begin errors++; $display("FAIL track_on_target c%0d: got %0b expected %0b", c, bus.o_On_Target, model_on_target()); end
    end
    checks++; if (bus.o_X_Pos !== 3 || bus.o_Y_Pos !== 10) begin errors++; $display("FAIL track_final: got %0d,%0d expected 3,10", bus.o_X_Pos, bus.o_Y_Pos); end
    checks++; if (bus.o_On_Target !== 1'b1 || rises != 1) begin errors++; $display("FAIL track_on_target_rise: got level %0b rises %0d expected 1 1", bus.o_On_Target, rises); end
  endtask

  task automatic test_fire_on_target();
    int n1, n2, nb;
    n1 = 0; n2 = 0; nb = 0;
    bus.i_Fire_Req = 1'b1;
    for (int s = 0; s < 12; s++) begin
      step();
      if (bus.o_Fire_Cmd == 4'd1) n1++;
      if (bus.o_Fire_Cmd == 4'd2) n2++;
      if (bus.o_Busy) nb++;
      checks++; if (bus.o_Fire_Cmd !== 4'(model_fire()) || bus.o_Busy !== (m_busy > 0)) begin errors++; $display("FAIL fire_seq s%0d: got cmd %0d busy %0b expected %0d %0b", s, bus.o_Fire_Cmd, bus.o_Busy, model_fire(), m_busy > 0); end
      checks++; if (bus.o_X_Pos !== 3 || bus.o_Y_Pos !== 10) begin errors++; $display("FAIL fire_interlock_pos s%0d: got %0d,%0d expected 3,10", s, bus.o_X_Pos, bus.o_Y_Pos); end
      case (s)
        0: begin bus.i_Fire_Req = 1'b0; bus.i_Switch_1 = 1'b1; bus.i_X_Target = 25'd7; end
        1: bus.i_Fire_Req = 1'b1;
        2: bus.i_Fire_Req = 1'b0;
        4: begin bus.i_Switch_1 = 1'b0; bus.i_X_Target = 25'd3; end
        default: ;
      endcase
    end
    checks++; if (n1 != FIRE_TICKS || n2 != RECOIL_TICKS || nb != 7) begin errors++; $display("FAIL fire_durations: got fire %0d recoil %0d busy %0d expected 4 3 7", n1, n2, nb); end
  endtask

  task automatic test_fire_off_target();
    bus.i_X_Target = 25'd5;
    bus.i_Y_Target = 25'd5;
    bus.i_Fire_Req = 1'b1;
    step();
    checks++; if (bus.o_Fire_Cmd !== 4'd0 || bus.o_Busy !== 1'b0) begin errors++; $display("FAIL fire_off_target: got cmd %0d busy %0b expected 0 0", bus.o_Fire_Cmd, bus.o_Busy); end
    bus.i_Fire_Req = 1'b0;
    step();
    bus.i_Manual = 1'b1;
    bus.i_Fire_Req = 1'b1;
    apply_reset();
    for (int c = 0; c < 3; c++) begin
      step();
      checks++; if (bus.o_Fire_Cmd !== 4'd0 || bus.o_Busy !== 1'b0) begin errors++; $display("FAIL fire_held_reset c%0d: got cmd %0d busy %0b expected 0 0", c, bus.o_Fire_Cmd, bus.o_Busy); end
    end
    bus.i_Fire_Req = 1'b0;
    step();
    bus.i_Fire_Req = 1'b1;
    step();
    checks++; if (bus.o_Fire_Cmd !== 4'd1 || bus.o_Busy !== 1'b1) begin errors++; $display("FAIL fire_new_edge: got cmd %0d busy %0b expected 1 1", bus.o_Fire_Cmd, bus.o_Busy); end
    bus.i_Fire_Req = 1'b0;
    for (int c = 0; c < 8; c++) step();
  endtask

  task automatic test_reset_mid_recoil();
    set_idle();
    apply_reset();
    bus.i_Manual = 1'b1;
    bus.i_Switch_4 = 1'b1;
    for (int c = 0; c < 3; c++) step();
    bus.i_Fire_Req = 1'b1;
    step();
    bus.i_Fire_Req = 1'b0;
    for (int c = 0; c < 5; c++) step();
    checks++; if (bus.o_Fire_Cmd !== 4'(model_fire()) || bus.o_Fire_Cmd !== 4'd2 || bus.o_Y_Pos !== 25'(m_y)) begin errors++; $display("FAIL pre_reset_recoil: got cmd %0d y %0d expected 2 %0d", bus.o_Fire_Cmd, bus.o_Y_Pos, m_y); end
    i_Rst = 1'b1;
    #2;
    checks++; if ({bus.o_Pan_Cmd, bus.o_Tilt_Cmd, bus.o_Fire_Cmd} !== 12'h000 || bus.o_Busy !== 1'b0 || bus.o_Y_Pos !== 0 || bus.o_X_Pos !== 0 || {bus.o_LED_1, bus.o_LED_2, bus.o_LED_3, bus.o_LED_4} !== 4'b0000) begin errors++; $display("FAIL async_reset: got pan %0d tilt %0d fire %0d busy %0b x %0d y %0d expected all 0", bus.o_Pan_Cmd, bus.o_Tilt_Cmd, bus.o_Fire_Cmd, bus.o_Busy, bus.o_X_Pos, bus.o_Y_Pos); end
    model_reset();
    @(posedge i_Clk);
    #1;
    i_Rst = 1'b0;
    step();
    checks++; if (bus.o_Busy !== 1'b0 || bus.o_Fire_Cmd !== 4'd0 || bus.o_Y_Pos !== 25'(m_y) || bus.o_Tilt_Cmd !== 4'(m_tilt)) begin errors++; $display("FAIL post_reset_ready: got busy %0b fire %0d y %0d tilt %0d expected 0 0 %0d %0d", bus.o_Busy, bus.o_Fire_Cmd, bus.o_Y_Pos, bus.o_Tilt_Cmd, m_y, m_tilt); end
  endtask

  task automatic test_random();
    set_idle();
    apply_reset();
    for (int c = 0; c < 400; c++) begin
      if ($urandom_range(0, 15) == 0) bus.i_Manual = ~bus.i_Manual;
      if ($urandom_range(0, 3) == 0) begin
        bus.i_Switch_1 = 1'($urandom_range(0, 1));
        bus.i_Switch_2 = 1'($urandom_range(0, 1));
        bus.i_Switch_3 = 1'($urandom_range(0, 1));
        bus.i_Switch_4 = 1'($urandom_range(0, 1));
      end
      if ($urandom_range(0, 19) == 0) begin
        bus.i_X_Target = 25'($urandom_range(0, 13));
        bus.i_Y_Target = ($urandom_range(0, 7) == 0) ? '1 : 25'($urandom_range(0, 13));
      end
      if ($urandom_range(0, 9) == 0) bus.i_Target_Valid = ~bus.i_Target_Valid;
      bus.i_Fire_Req = ($urandom_range(0, 5) == 0);
      step();
      checks++; if (bus.o_Pan_Cmd !== 4'(m_pan) || bus.o_Tilt_Cmd !== 4'(m_tilt)) begin errors++; $display("FAIL rnd_cmds c%0d: got %0d,%0d expected %0d,%0d", c, bus.o_Pan_Cmd, bus.o_Tilt_Cmd, m_pan, m_tilt); end
      checks++; if (bus.o_X_Pos !== 25'(m_x) || bus.o_Y_Pos !== 25'(m_y)) begin errors++; $display("FAIL rnd_pos c%0d: got %0d,%0d expected %0d,%0d", c, bus.o_X_Pos, bus.o_Y_Pos, m_x, m_y); end
      checks++; if (bus.o_Fire_Cmd !== 4'(model_fire()) || bus.o_Busy !== (m_busy > 0)) begin errors++; $display("FAIL rnd_fire c%0d: got cmd %0d busy %0b expected %0d %0b", c, bus.o_Fire_Cmd, bus.o_Busy, model_fire(), m_busy > 0); end
      checks++; if ({bus.o_LED_1, bus.o_LED_2, bus.o_LED_3, bus.o_LED_4} !== {m_pan == 1, m_pan == 2, m_tilt == 1, m_tilt == 2}) begin errors++; $display("FAIL rnd_leds c%0d: got %b expected %b", c, {bus.o_LED_1, bus.o_LED_2, bus.o_LED_3, bus.o_LED_4}, {m_pan == 1, m_pan == 2, m_tilt == 1, m_tilt == 2}); end
      checks++; if (bus.o_On_Target !== model_on_target()) begin errors++; $display("FAIL rnd_on_target c%0d: got %0b expected %0b", c, bus.o_On_Target, model_on_target()); end
    end
  endtask

  initial begin
    set_idle();
    model_reset();
    test_reset();
    test_manual_pan();
    test_manual_conflict();
    test_auto_track();
    test_fire_on_target();
    test_fire_off_target();
    test_reset_mid_recoil();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/turret_sequencer.md
# turret_sequencer

Central controller for the pan/tilt/fire turret. It arbitrates pan and tilt motion between manual switch commands and automatic target tracking. It tracks saturating axis position counters and sequences the timed fire/recoil cycle, with a motion interlock during firing. Its outputs feed the pan, tilt and fire servo PWM drivers as 4-bit command codes.

## Interface
- POS_W, 25: width of axis position counters and targets.
- POS_MAX, 22727272: upper axis bound; positions range 0..POS_MAX.
- FIRE_TICKS, 22727272: cycles the fire command is held.
- RECOIL_TICKS, 22727272: cycles the recoil command is held.
- TICK_W, 31: fire/recoil counter width.

Ports:
- i_Clk  in  1  system clock; all state changes on rising edge.
- i_Rst  in  1  asynchronous, active-high reset.
- i_Manual  in  1  1 = manual (switch) mode, 0 = automatic tracking.
- i_Switch_1 / i_Switch_2  in  1 each  manual pan left / right.
- i_Switch_3 / i_Switch_4  in  1 each  manual tilt up / down.
- i_Fire_Req  in  1  fire trigger; rising-edge sensitive.
- i_Target_Valid  in  1  automatic target present.
- i_X_Target, i_Y_Target  in  POS_W  automatic target position.
- o_Pan_Cmd  out  4  0 stop, 1 left, 2 right, 5 release.
- o_Tilt_Cmd  out  4  0 stop, 1 up, 2 down, 5 release.
- o_Fire_Cmd  out  4  0 idle, 1 fire, 2 recoil.
- o_X_Pos, o_Y_Pos  out  POS_W  current axis positions.
- o_On_Target  out  1  i_Target_Valid and both positions equal the clamped targets.
- o_Busy  out  1  fire sequence in progress.
- o_LED_1..o_LED_4  out  1 each  pan-left, pan-right, tilt-up, tilt-down active (cmd == 1 / 2).

## Operation
- Sequencer states: READY, FIRE, RECOIL. Reset enters READY.
- Reset values: all cmds 0, positions 0, o_Busy 0, LEDs 0, fire counter 0, fire-edge history register 1. The history reset value of 1 prevents a trigger held through reset from firing.
- Per-axis move decision in READY, pan shown; tilt is identical with up decrementing and down incrementing:
  - Manual mode: Switch_1 & !Switch_2 gives left if X>0. !Switch_1 & Switch_2 gives right if X<POS_MAX. Both or neither gives no move.
  - Auto mode with i_Target_Valid: target is clamped to POS_MAX. X>target gives left, X<target gives right, equal gives no move.
  - Auto mode without i_Target_Valid: no move.
- Command register, per axis:
  - Move left/up: cmd 1 and position −1 on the same edge.
  - Move right/down: cmd 2 and position +1 on the same edge.
  - No move, previous cmd 1 or 2: cmd 5 for exactly one cycle, then 0.
  - Otherwise: cmd 0.
- Positions saturate and never leave 0..POS_MAX.
- Mode change on i_Manual applies to the next decision. An axis that stops as a result emits the release code 5.
- Fire acceptance: a rising edge of i_Fire_Req (high now, low at the previous sample) in READY is accepted if:
  - manual mode, or
  - auto mode with o_On_Target = 1.
  - If neither holds, the edge is dropped.
- FIRE: o_Fire_Cmd = 1 for FIRE_TICKS cycles, then RECOIL. RECOIL: o_Fire_Cmd = 2 for RECOIL_TICKS cycles, then READY with o_Fire_Cmd = 0.
- Interlock in FIRE/RECOIL:
  - No position changes.
  - Axis cmds follow the no-move rule, so an axis moving at acceptance gives one 5, then 0.
  - Switches and targets are ignored.
  - Fire edges are ignored and not queued.
- o_Busy = 1 exactly while in FIRE or RECOIL.
- Asynchronous reset at any time, including mid-fire or mid-move, returns every register to its reset value immediately.

## Timing
- All outputs are registered. Inputs sampled at edge k are reflected in the outputs after edge k (1-cycle latency).
- Position and cmd update on the same edge, so o_X_Pos reflects every emitted move.
- Fire edge sampled at edge k:
  - o_Fire_Cmd = 1 and o_Busy = 1 from edge k.
  - o_Fire_Cmd = 2 from edge k+FIRE_TICKS.
  - o_Fire_Cmd = 0 and o_Busy = 0 from edge k+FIRE_TICKS+RECOIL_TICKS.
- First motion decision after the READY return is made at that same edge.
- o_On_Target is combinational from registered positions and the current target inputs.

## Test plan
Parameters for all scenarios: POS_MAX=10, FIRE_TICKS=4, RECOIL_TICKS=3.
- Manual mode, Switch_2 held 15 cycles from reset -> pan cmd 2 for 10 cycles, o_X_Pos reaches 10, then cmd 5 for one cycle, then 0; X never exceeds 10; o_LED_2 tracks cmd 2.
- Manual mode, Switch_1 and Switch_2 both high -> pan cmd 0, X unchanged; Switch_1 alone at X=0 -> cmd 0.
- Auto mode, target (3,12), valid -> X steps 0→3 and Y steps 0→10 (clamped); o_On_Target rises once X=3, Y=10.
- Auto mode, on target, fire pulse -> Fire_Cmd 1 for exactly 4 cycles, 2 for 3 cycles, then 0; o_Busy high 7 cycles; a second fire pulse during busy is ignored; Switch/target changes during busy leave positions unchanged.
- Auto mode, off target, fire pulse -> no fire. i_Fire_Req held high across reset release -> no fire until a new rising edge.
- Reset asserted mid-RECOIL while tilt is moving -> all outputs 0 immediately; after release, READY with positions 0.
